// File: rtl/mem_store_buffer.sv
// In-order store buffer between M0 and the 128-word data memory write port.
// Drains the oldest entry under valid/ready and forwards the youngest matching store to loads.
module mem_store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 7
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      st_valid_i,
  input  logic [31:0]               st_addr_i,
  input  logic [31:0]               st_data_i,
  output logic                      st_ready_o,
  input  logic [31:0]               ld_addr_i,
  output logic                      fwd_hit_o,
  output logic [31:0]               fwd_data_o,
  output logic                      mem_wr_en_o,
  output logic [ADDR_W-1:0]         mem_wr_addr_o,
  output logic [31:0]               mem_wr_data_o,
  input  logic                      mem_wr_ready_i,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [31:0]       data_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic push;
  logic pop;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{st_addr_i[31:ADDR_W+2], st_addr_i[1:0],
                              ld_addr_i[31:ADDR_W+2], ld_addr_i[1:0]};

  // Drain side is decoded straight from registered state.
  assign empty_o       = (count_q == '0);
  assign st_ready_o    = (count_q != CNT_W'(DEPTH));
  assign mem_wr_en_o   = !empty_o;
  assign mem_wr_addr_o = addr_q[head_q];
  assign mem_wr_data_o = data_q[head_q];
  assign count_o       = count_q;

  assign push = st_valid_i && st_ready_o;
  assign pop  = mem_wr_en_o && mem_wr_ready_i;

  // Next-state for entries, pointers and occupancy.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = st_addr_i[ADDR_W+1:2];
      data_d[tail_q]  = st_data_i;
      tail_d          = tail_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    idx        = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if (valid_q[idx] && (addr_q[idx] == ld_addr_i[ADDR_W+1:2])) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer: reset, drain order, backpressure, forwarding, wrap-around.
module tb_mem_store_buffer;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic [31:0] ld_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        mem_wr_en;
  logic [6:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ready;
  logic [2:0]  count;
  logic        empty;

  int checks = 0;
  int errors = 0;

  logic [38:0] wr_log [$];

  mem_store_buffer #(.DEPTH(4), .ADDR_W(7)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .st_valid_i     (st_valid),
    .st_addr_i      (st_addr),
    .st_data_i      (st_data),
    .st_ready_o     (st_ready),
    .ld_addr_i      (ld_addr),
    .fwd_hit_o      (fwd_hit),
    .fwd_data_o     (fwd_data),
    .mem_wr_en_o    (mem_wr_en),
    .mem_wr_addr_o  (mem_wr_addr),
    .mem_wr_data_o  (mem_wr_data),
    .mem_wr_ready_i (mem_wr_ready),
    .count_o        (count),
    .empty_o        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted memory write.
  always @(posedge clk) begin
    if (!rst && mem_wr_en && mem_wr_ready) wr_log.push_back({mem_wr_addr, mem_wr_data});
  end

  task automatic check(input string tag, input logic [38:0] obs, input logic [38:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [38:0] log_at(input int i);
    if (i < wr_log.size()) return wr_log[i];
    return '1;
  endfunction

  task automatic drain(input string tag);
    int n;
    st_valid     = 1'b0;
    mem_wr_ready = 1'b1;
    n = 0;
    while (!empty && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 39'(empty), 39'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   guard;

    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_addr = '0; mem_wr_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_st_ready", 39'(st_ready), 39'(1));
    check("rst_wr_en",    39'(mem_wr_en), 39'(0));
    check("rst_wr_addr",  39'(mem_wr_addr), 39'(0));
    check("rst_wr_data",  39'(mem_wr_data), 39'(0));
    check("rst_fwd_hit",  39'(fwd_hit), 39'(0));
    check("rst_fwd_data", 39'(fwd_data), 39'(0));
    check("rst_empty",    39'(empty), 39'(1));
    check("rst_count",    39'(count), 39'(0));
    rst = 1'b0;

    // Reset mid-drain
    wr_log.delete();
    mem_wr_ready = 1'b0;
    st_valid = 1'b1;
    st_addr = 32'h14; st_data = 32'hA0; @(negedge clk);
    st_addr = 32'h18; st_data = 32'hA1; @(negedge clk);
    st_addr = 32'h1C; st_data = 32'hA2; @(negedge clk);
    st_valid = 1'b0;
    check("mid_count3", 39'(count), 39'(3));
    check("mid_wr_en",  39'(mem_wr_en), 39'(1));
    #2 rst = 1'b1;
    ld_addr = 32'h14;
    #1;
    check("mid_rst_count",    39'(count), 39'(0));
    check("mid_rst_wr_en",    39'(mem_wr_en), 39'(0));
    check("mid_rst_st_ready", 39'(st_ready), 39'(1));
    check("mid_rst_empty",    39'(empty), 39'(1));
    check("mid_rst_fwd",      39'(fwd_hit), 39'(0));
    @(negedge clk);
    rst = 1'b0;
    mem_wr_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_no_writes", 39'(wr_log.size()), 39'(0));

    // Single store
    wr_log.delete();
    st_valid = 1'b1; st_addr = 32'h14; st_data = 32'hDEADBEEF;
    @(negedge clk);
    st_valid = 1'b0;
    ld_addr = 32'h14;
    #1;
    check("single_wr_en",    39'(mem_wr_en), 39'(1));
    check("single_wr_addr",  39'(mem_wr_addr), 39'(5));
    check("single_wr_data",  39'(mem_wr_data), 39'(32'hDEADBEEF));
    check("single_fwd_hit",  39'(fwd_hit), 39'(1));
    check("single_fwd_data", 39'(fwd_data), 39'(32'hDEADBEEF));
    @(negedge clk);
    check("single_empty", 39'(empty), 39'(1));
    check("single_log_n", 39'(wr_log.size()), 39'(1));
    check("single_log0",  log_at(0), {7'd5, 32'hDEADBEEF});

    // Fill, backpressure and push/pop at full
    wr_log.delete();
    mem_wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("fill_rdy", 39'(st_ready), 39'(1));
      st_valid = 1'b1; st_addr = 32'(4 * i); st_data = 32'h100 + 32'(i);
      @(negedge clk);
    end
    st_addr = 32'h10; st_data = 32'h555;
    check("full_count", 39'(count), 39'(4));
    check("full_rdy",   39'(st_ready), 39'(0));
    @(negedge clk);
    check("drop_count",   39'(count), 39'(4));
    check("hold_wr_addr", 39'(mem_wr_addr), 39'(0));
    check("hold_wr_data", 39'(mem_wr_data), 39'(32'h100));
    mem_wr_ready = 1'b1;
    @(negedge clk);
    check("full_pop_count", 39'(count), 39'(3));
    check("full_pop_rdy",   39'(st_ready), 39'(1));
    @(negedge clk);
    check("pushpop_count", 39'(count), 39'(3));
    drain("fill_drain");
    check("fill_log_n", 39'(wr_log.size()), 39'(5));
    for (int i = 0; i < 4; i++)
      check("fill_order", log_at(i), {7'(i), 32'h100 + 32'(i)});
    check("fill_fifth", log_at(4), {7'd4, 32'h555});

    // Forwarding priority and aliasing
    wr_log.delete();
    mem_wr_ready = 1'b0;
    st_valid = 1'b1;
    st_addr = 32'h20; st_data = 32'h11111111; @(negedge clk);
    st_addr = 32'h20; st_data = 32'h22222222; @(negedge clk);
    st_valid = 1'b0;
    ld_addr = 32'h23; #1;
    check("fwd_young_hit",  39'(fwd_hit), 39'(1));
    check("fwd_young_data", 39'(fwd_data), 39'(32'h22222222));
    ld_addr = 32'h24; #1;
    check("fwd_miss_hit",  39'(fwd_hit), 39'(0));
    check("fwd_miss_data", 39'(fwd_data), 39'(0));
    ld_addr = 32'h220; #1;
    check("fwd_alias_hit",  39'(fwd_hit), 39'(1));
    check("fwd_alias_data", 39'(fwd_data), 39'(32'h22222222));
    st_valid = 1'b1; st_addr = 32'h30; st_data = 32'h33333333;
    ld_addr = 32'h30; #1;
    check("fwd_same_cycle", 39'(fwd_hit), 39'(0));
    st_valid = 1'b0;
    drain("fwd_drain");
    check("fwd_log_n", 39'(wr_log.size()), 39'(2));
    check("fwd_log0",  log_at(0), {7'd8, 32'h11111111});
    check("fwd_log1",  log_at(1), {7'd8, 32'h22222222});

    // Wrap-around with toggling ready
    wr_log.delete();
    mem_wr_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      st_valid = 1'b1; st_addr = 32'(4 * (i - 1)); st_data = 32'(i);
      acc = 1'b0; guard = 0;
      while (!acc && guard < 20) begin
        acc = st_ready;
        mem_wr_ready = ~mem_wr_ready;
        @(negedge clk);
        guard++;
      end
      check("wrap_accept", 39'(acc), 39'(1));
    end
    drain("wrap_drain");
    check("wrap_log_n", 39'(wr_log.size()), 39'(10));
    for (int i = 0; i < 10; i++)
      check("wrap_order", log_at(i), {7'(i), 32'(i + 1)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_store_buffer.md
# mem_store_buffer

Write-side companion to the M1 data-memory read stage: accepts word stores from the M0 stage, holds them in a small in-order FIFO, and drains them into the 128-word data memory write port under a valid/ready handshake. It also forwards the youngest buffered store data to a load that reads the same word. This decouples store issue from memory-port availability.

## Interface
- DEPTH, 4, number of buffered stores (power of two, ≥2)
- ADDR_W, 7, data-memory word-address width (address bits [ADDR_W+1:2])

- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- st_valid  in  1  store request from M0
- st_addr  in  32  store byte address; only [ADDR_W+1:2] used
- st_data  in  32  store word
- st_ready  out  1  buffer can accept a store this cycle
- ld_addr  in  32  load byte address for forwarding lookup
- fwd_hit  out  1  a buffered store matches ld_addr word
- fwd_data  out  32  data of youngest matching entry, 0 when no hit
- mem_wr_en  out  1  write request to data memory (valid)
- mem_wr_addr  out  ADDR_W  word address of head entry
- mem_wr_data  out  32  data of head entry
- mem_wr_ready  in  1  memory accepts write this cycle
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0

## Operation
- Storage: DEPTH entries {valid, addr[ADDR_W-1:0], data[31:0]}, circular head (oldest) and tail (next free) pointers, each wrapping DEPTH-1 -> 0.
- st_ready = (count != DEPTH); it does not look at same-cycle pop.
- Push: st_valid && st_ready -> write entry at tail with st_addr[ADDR_W+1:2] and st_data, set valid, tail+1, count+1.
- st_valid while !st_ready: store is ignored. The M0 stage must stall and hold it.
- Drain: mem_wr_en = !empty; mem_wr_addr/mem_wr_data = head entry fields. All three come combinationally from registered state.
- Pop: mem_wr_en && mem_wr_ready -> clear head valid, head+1, count-1.
- Payload stays stable while mem_wr_en=1 && mem_wr_ready=0.
- Simultaneous push and pop: both take effect, count unchanged.
- Stores reach memory in issue order. Two stores to the same word are both written, oldest first.
- Forwarding: combinational compare of ld_addr[ADDR_W+1:2] against all valid entries.
  - The youngest match (closest to tail) wins.
  - Only registered entries are compared. A store arriving in the same cycle is not forwarded.
  - The entry being popped this cycle still forwards.
- Address bits [1:0] and above ADDR_W+1 are ignored, so higher addresses alias. This matches the data-memory range.

## Timing
- Reset (asynchronous, active-high): head=tail=0, count=0, all valid=0, entry data/addr=0.
  - Outputs while in reset: st_ready=1, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, fwd_hit=0, fwd_data=0, empty=1.
- Reset during operation: pending stores are discarded, not written to memory. This is the required behaviour.
- Store latency: push at edge N -> mem_wr_en=1 with that entry in cycle N+1 if the buffer was empty. It also becomes forwardable in cycle N+1.
- Throughput: one push and one pop per cycle sustained. With mem_wr_ready held 1, count never exceeds 1 under back-to-back stores.
- Full: count==DEPTH -> st_ready=0 in that same cycle. st_ready returns to 1 the cycle after a pop.
- Empty: mem_wr_en=0. mem_wr_ready is ignored.
- Pointer wrap-around must not disturb ordering or forwarding priority.

## Test plan
- Reset mid-drain: fill 3 entries with mem_wr_ready=0, assert reset -> count=0, mem_wr_en=0, st_ready=1 immediately. After release, no write to 0x05 or any other address ever occurs.
- Single store: store addr 0x14, data 0xDEADBEEF, mem_wr_ready=1 -> next cycle mem_wr_en=1, mem_wr_addr=5, mem_wr_data=0xDEADBEEF. The following cycle shows empty=1.
- Fill and backpressure: mem_wr_ready=0, push addrs 0x00,0x04,0x08,0x0C, then a fifth store -> st_ready=0 and count=4. The fifth store is dropped until mem_wr_ready=1. Drain order on mem_wr_addr is 0,1,2,3.
- Forward priority: with mem_wr_ready=0, push 0x20/0x11111111 then 0x20/0x22222222; set ld_addr=0x23 -> fwd_hit=1, fwd_data=0x22222222. ld_addr=0x24 -> fwd_hit=0, fwd_data=0.
- Simultaneous push/pop at full: count=4, mem_wr_ready=1, st_valid=1 -> pop occurs, no push, count=3. The next cycle accepts the store and count=3.
- Wrap-around: issue 10 stores (data 1..10, addr 4*i) with mem_wr_ready toggling 1/0 each cycle -> memory sees data 1..10 in order at word addresses 0..9. No loss or duplication.
